// File: rtl/imem_access_arbiter.sv
// Instruction-memory arbiter: loader-only BOOT phase, then round-robin fetch/loader sharing in RUN.
// Optional macro IMEM_WRITE_PROTECT_EN rejects loader writes once in RUN.
module imem_access_arbiter #(
  parameter int          AW        = 22,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter bit          BOOT_SKIP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  output logic          f_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  input  logic          l_done,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          booting
);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  typedef enum logic {RR_FETCH, RR_LOADER} rr_t;

  state_t      state_q, state_d;
  rr_t         rr_last_q, rr_last_d;
  logic        f_pend_q, f_pend_d;
  logic        f_flt_q, f_flt_d;
  logic        l_pend_q, l_pend_d;
  logic        l_err_q, l_err_d;
  logic [31:0] f_hold_q, f_hold_d;
  logic [31:0] l_hold_q, l_hold_d;
  logic        f_fault, l_fault, l_wp_rej, l_rej;

  function automatic logic addr_fault(input logic [31:0] a);
    addr_fault = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    // Grants are suppressed during reset so the memory sees no stray access.
    if (!rst) begin
      if (state_q == ST_BOOT) begin
        l_gnt = l_req;
      end else if (f_req && l_req) begin
        if (rr_last_q == RR_LOADER) f_gnt = 1'b1;
        else                        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end

    f_fault = addr_fault(f_addr);
    l_fault = addr_fault(l_addr);
`ifdef IMEM_WRITE_PROTECT_EN
    l_wp_rej = (state_q == ST_RUN) && l_we;
`else
    l_wp_rej = 1'b0;
`endif
    l_rej = l_fault || l_wp_rej;

    f_stall = f_req && !f_gnt;
    m_en    = (f_gnt && !f_fault) || (l_gnt && !l_rej);
    m_we    = l_gnt && !l_rej && l_we;
    m_addr  = l_gnt ? l_addr[AW+1:2] : f_addr[AW+1:2];
    m_wdata = l_wdata;

    f_pend_d  = f_gnt && !f_fault;
    f_flt_d   = f_gnt && f_fault;
    l_pend_d  = l_gnt && !l_rej && !l_we;
    l_err_d   = l_gnt && l_rej;
    rr_last_d = f_gnt ? RR_FETCH : (l_gnt ? RR_LOADER : rr_last_q);
    state_d   = (state_q == ST_BOOT && l_done) ? ST_RUN : state_q;

    // Response side: pending flags are registered, so data can only land on its owner.
    f_rvalid = !rst && (f_pend_q || f_flt_q);
    f_err    = !rst && f_flt_q;
    l_rvalid = !rst && l_pend_q;
    l_err    = !rst && l_err_q;
    f_rdata  = f_hold_q;
    if (!rst && f_flt_q)       f_rdata = NOP_INSTR;
    else if (!rst && f_pend_q) f_rdata = m_rdata;
    l_rdata  = (!rst && l_pend_q) ? m_rdata : l_hold_q;
    f_hold_d = f_rdata;
    l_hold_d = l_rdata;
    booting  = (state_q == ST_BOOT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT_SKIP ? ST_RUN : ST_BOOT;
      rr_last_q <= RR_LOADER;
      f_pend_q  <= 1'b0;
      f_flt_q   <= 1'b0;
      l_pend_q  <= 1'b0;
      l_err_q   <= 1'b0;
      f_hold_q  <= 32'd0;
      l_hold_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      f_pend_q  <= f_pend_d;
      f_flt_q   <= f_flt_d;
      l_pend_q  <= l_pend_d;
      l_err_q   <= l_err_d;
      f_hold_q  <= f_hold_d;
      l_hold_q  <= l_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: boot load, round-robin table, faults, write protect, reset, BOOT_SKIP.
module tb_imem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we, l_done;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, f_err, f_stall;
  logic [31:0] f_rdata, l_rdata, m_wdata;
  logic        l_gnt, l_rvalid, l_err, m_en, m_we, booting;
  logic [21:0] m_addr;
  logic [31:0] m_rdata;

  logic        s_f_req;
  logic [31:0] s_f_addr;
  logic        s_f_gnt, s_f_rvalid, s_f_err, s_f_stall;
  logic [31:0] s_f_rdata, s_l_rdata, s_m_wdata;
  logic        s_l_gnt, s_l_rvalid, s_l_err, s_m_en, s_m_we, s_booting;
  logic [21:0] s_m_addr;
  logic [31:0] s_m_rdata = 32'h1234_5678;

  logic [31:0] mem [0:255];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_access_arbiter #(.AW(22)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err), .f_stall(f_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .booting(booting)
  );

  imem_access_arbiter #(.AW(22), .BOOT_SKIP(1'b1)) u_skip (
    .clk(clk), .rst(rst),
    .f_req(s_f_req), .f_addr(s_f_addr), .f_gnt(s_f_gnt), .f_rvalid(s_f_rvalid),
    .f_rdata(s_f_rdata), .f_err(s_f_err), .f_stall(s_f_stall),
    .l_req(1'b0), .l_we(1'b0), .l_addr(32'd0), .l_wdata(32'd0), .l_done(1'b0),
    .l_gnt(s_l_gnt), .l_rvalid(s_l_rvalid), .l_rdata(s_l_rdata), .l_err(s_l_err),
    .m_en(s_m_en), .m_we(s_m_we), .m_addr(s_m_addr), .m_wdata(s_m_wdata), .m_rdata(s_m_rdata),
    .booting(s_booting)
  );

  // Registered-read memory model, aliased onto 256 words.
  always @(posedge clk) begin
    if (m_en && m_we)  mem[m_addr[7:0]] <= m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr[7:0]];
  end

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lr;
    logic        lw;
    logic [31:0] la;
    logic [3:0]  gm;   // {f_gnt, l_gnt, m_en, m_we}
    logic [21:0] ma;
    logic [3:0]  rsp;  // {f_rvalid, f_err, l_rvalid, l_err} one cycle later
    logic [31:0] frd;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic lr,
                              input logic lw, input logic [31:0] la, input logic [3:0] gm,
                              input logic [21:0] ma, input logic [3:0] rsp,
                              input logic [31:0] frd, input logic [31:0] lrd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la;
    v.gm = gm; v.ma = ma; v.rsp = rsp; v.frd = frd; v.lrd = lrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp8;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    m_rdata = 32'd0;
    rst = 1'b1; f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_done = 0;
    s_f_req = 0; s_f_addr = 0;

    vecs[0]  = mk(0, 32'h0,        1, 0, 32'h4,        4'b0110, 22'h1,      4'b0010, 32'h00212223, 32'h00212223);
    vecs[1]  = mk(1, 32'h4,        1, 0, 32'h0,        4'b1010, 22'h1,      4'b1000, 32'h00212223, 32'h00212223);
    vecs[2]  = mk(1, 32'h4,        1, 0, 32'h0,        4'b0110, 22'h0,      4'b0010, 32'h00212223, 32'h00500113);
    vecs[3]  = mk(1, 32'h0,        1, 0, 32'h4,        4'b1010, 22'h0,      4'b1000, 32'h00500113, 32'h00500113);
    vecs[4]  = mk(1, 32'h0,        1, 0, 32'h4,        4'b0110, 22'h1,      4'b0010, 32'h00500113, 32'h00212223);
    vecs[5]  = mk(1, 32'h2,        0, 0, 32'h0,        4'b1000, 22'h0,      4'b1100, 32'h00000013, 32'h00212223);
    vecs[6]  = mk(0, 32'h0,        1, 0, 32'h1000_0000, 4'b0100, 22'h0,     4'b0001, 32'h00000013, 32'h00212223);
    vecs[7]  = mk(0, 32'h0,        1, 1, 32'h6,        4'b0100, 22'h0,      4'b0001, 32'h00000013, 32'h00212223);
    vecs[8]  = mk(1, 32'h0100_0000, 0, 0, 32'h0,       4'b1000, 22'h0,      4'b1100, 32'h00000013, 32'h00212223);
    vecs[9]  = mk(1, 32'h0,        0, 0, 32'h0,        4'b1010, 22'h0,      4'b1000, 32'h00500113, 32'h00212223);
    vecs[10] = mk(0, 32'h0,        1, 0, 32'h00FF_FFFC, 4'b0110, 22'h3FFFFF, 4'b0010, 32'h00500113, 32'hA5A500FF);
    vecs[11] = mk(0, 32'h0,        0, 0, 32'h0,        4'b0000, 22'h0,      4'b0000, 32'h00500113, 32'hA5A500FF);
    vecs[12] = mk(1, 32'h3,        1, 0, 32'h4,        4'b1000, 22'h0,      4'b1100, 32'h00000013, 32'hA5A500FF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_booting", booting, 1);
    chk("rst_skip_booting", s_booting, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_err", l_err, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    rst = 1'b0;

    // Boot load with a fetch pending that must stay stalled
    f_req = 1; f_addr = 32'h4; l_req = 1; l_we = 1; l_addr = 32'h0; l_wdata = 32'h00500113;
    s_f_req = 1; s_f_addr = 32'h0;
    #1;
    chk("boot1_f_gnt", f_gnt, 0);
    chk("boot1_f_stall", f_stall, 1);
    chk("boot1_l_gnt", l_gnt, 1);
    chk("boot1_m_en", m_en, 1);
    chk("boot1_m_we", m_we, 1);
    chk("boot1_m_addr", m_addr, 0);
    chk("skip_f_gnt", s_f_gnt, 1);
    chk("skip_m_en", s_m_en, 1);
    tick();
    s_f_req = 0;
    chk("skip_f_rvalid", s_f_rvalid, 1);
    chk("skip_f_rdata", s_f_rdata, 32'h1234_5678);
    l_addr = 32'h4; l_wdata = 32'h00212223; l_done = 1;
    #1;
    chk("boot2_f_gnt", f_gnt, 0);
    chk("boot2_l_gnt", l_gnt, 1);
    chk("boot2_m_we", m_we, 1);
    chk("boot2_m_addr", m_addr, 1);
    chk("boot2_booting", booting, 1);
    tick();
    l_req = 0; l_we = 0; l_done = 0;
    #1;
    chk("run_booting", booting, 0);
    chk("run_f_gnt", f_gnt, 1);
    chk("run_m_en", m_en, 1);
    chk("run_m_we", m_we, 0);
    chk("run_m_addr", m_addr, 1);
    tick();
    f_req = 0;
    chk("boot_fetch_rvalid", f_rvalid, 1);
    chk("boot_fetch_err", f_err, 0);
    chk("boot_fetch_rdata", f_rdata, 32'h00212223);

    // Table: round-robin, faults, range boundary, rdata hold
    for (int i = 0; i < 13; i++) begin
      f_req = vecs[i].fr; f_addr = vecs[i].fa;
      l_req = vecs[i].lr; l_we = vecs[i].lw; l_addr = vecs[i].la;
      #1;
      chk($sformatf("v%0d_gnt_men_mwe", i), {28'd0, f_gnt, l_gnt, m_en, m_we}, {28'd0, vecs[i].gm});
      if (vecs[i].gm[1]) chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].ma);
      tick();
      chk($sformatf("v%0d_rsp", i), {28'd0, f_rvalid, f_err, l_rvalid, l_err}, {28'd0, vecs[i].rsp});
      chk($sformatf("v%0d_f_rdata", i), f_rdata, vecs[i].frd);
      chk($sformatf("v%0d_l_rdata", i), l_rdata, vecs[i].lrd);
    end
    f_req = 0; l_req = 0; l_we = 0;

    // RUN loader write @0x8, read back, then fetch it
`ifdef IMEM_WRITE_PROTECT_EN
    exp8 = 32'hA5A5_0002;
`else
    exp8 = 32'hDEAD_BEEF;
`endif
    l_req = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr8_l_gnt", l_gnt, 1);
`ifdef IMEM_WRITE_PROTECT_EN
    chk("wr8_m_en", m_en, 0);
`else
    chk("wr8_m_en", m_en, 1);
    chk("wr8_m_we", m_we, 1);
    chk("wr8_m_wdata", m_wdata, 32'hDEAD_BEEF);
`endif
    tick();
    l_we = 0;
`ifdef IMEM_WRITE_PROTECT_EN
    chk("wr8_l_err", l_err, 1);
`else
    chk("wr8_l_err", l_err, 0);
`endif
    tick();
    l_req = 0;
    chk("rd8_l_rvalid", l_rvalid, 1);
    chk("rd8_l_rdata", l_rdata, exp8);
    f_req = 1; f_addr = 32'h8;
    tick();
    f_req = 0;
    chk("fetch8_rvalid", f_rvalid, 1);
    chk("fetch8_rdata", f_rdata, exp8);

    // Reset in the cycle after a fetch grant
    f_req = 1; f_addr = 32'h0;
    #1;
    chk("rstmid_f_gnt", f_gnt, 1);
    tick();
    rst = 1; f_req = 0;
    #1;
    chk("rstmid_f_rvalid", f_rvalid, 0);
    tick();
    chk("rstmid_booting", booting, 1);
    chk("rstmid_f_rvalid2", f_rvalid, 0);
    chk("rstmid_f_rdata", f_rdata, 0);
    chk("rstmid_skip_booting", s_booting, 0);
    rst = 0;
    f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 0; l_addr = 32'h0;
    #1;
    chk("reboot_f_gnt", f_gnt, 0);
    chk("reboot_l_gnt", l_gnt, 1);
    tick();
    f_req = 0; l_req = 0;
    chk("reboot_l_rvalid", l_rvalid, 1);
    chk("reboot_l_rdata", l_rdata, 32'h00500113);
    chk("reboot_f_rvalid", f_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
